// File: rtl/imm_ext_unit.sv
// imm_ext_unit: registered immediate/branch-target generator with a small output FIFO.
// Results are computed at push time, so imm_out depends only on stored state.
module imm_ext_unit #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                instr,
   input  logic [DATA_W-1:0]          pc,
   input  logic [2:0]                 mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          imm_out,
   output logic                       mode_err,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] s, z, pc4, res;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  err_mem;
   logic [AW-1:0]     wr, rd;
   logic              push, pop, unused;
   assign imm    = instr[IMM_W-1:0];
   assign s      = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   assign z      = {{(DATA_W-IMM_W){1'b0}}, imm};
   assign pc4    = pc + DATA_W'(4);
   assign unused = ^instr;
   always_comb
      res = mode == 3'd0 ? z :
            mode == 3'd1 ? s :
            mode == 3'd2 ? z << 16 :
            mode == 3'd3 ? s << 2 :
            mode == 3'd4 ? pc4 + (s << 2) :
            mode == 3'd5 ? {pc4[DATA_W-1:28], instr[25:0], 2'b00} :
            mode == 3'd6 ? {{(DATA_W-5){1'b0}}, instr[10:6]} :
                           '0;
   // Ready comes from the registered count only; a same-cycle pop cannot free a slot.
   assign in_ready  = count != CW'(DEPTH);
   assign out_valid = count != '0;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign imm_out   = out_valid ? mem[rd] : '0;
   assign mode_err  = out_valid & err_mem[rd];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         count <= '0;
         wr    <= '0;
         rd    <= '0;
      end else if (flush) begin
         count <= '0;
         wr    <= '0;
         rd    <= '0;
      end else begin
         count <= count + CW'(push) - CW'(pop);
         if (push) wr <= wr == AW'(DEPTH-1) ? '0 : wr + AW'(1);
         if (pop)  rd <= rd == AW'(DEPTH-1) ? '0 : rd + AW'(1);
      end
   always_ff @(posedge clk)
      if (push & ~flush) begin
         mem[wr]     <= res;
         err_mem[wr] <= mode == 3'd7;
      end
endmodule

// File: tb/tb_imm_ext_unit.sv
// tb_imm_ext_unit: directed vectors against an arithmetic reference model of the FIFO and formats.
module tb_imm_ext_unit;
   logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
   logic        in_ready, out_valid, mode_err;
   logic [31:0] instr = 0, pc = 0, imm_out;
   logic [2:0]  mode = 0;
   logic [1:0]  count;
   logic [32:0] q[$];
   int          vectors = 0, miscompares = 0;

   imm_ext_unit dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
      .imm_out(imm_out), .mode_err(mode_err), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [32:0] model(input logic [2:0] m, input logic [31:0] i, input logic [31:0] p);
      int s;
      s = int'($signed(i[15:0]));
      case (m)
         3'd0: return {1'b0, i & 32'h0000FFFF};
         3'd1: return {1'b0, 32'(s)};
         3'd2: return {1'b0, (i & 32'h0000FFFF) * 32'd65536};
         3'd3: return {1'b0, 32'(s * 4)};
         3'd4: return {1'b0, p + 32'd4 + 32'(s * 4)};
         3'd5: return {1'b0, ((p + 32'd4) & 32'hF0000000) | ((i & 32'h03FFFFFF) * 32'd4)};
         3'd6: return {1'b0, (i >> 6) & 32'd31};
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      bit p, d;
      if (rst || flush) q.delete();
      else begin
         p = in_valid && q.size() < 2;
         d = out_ready && q.size() > 0;
         if (d) void'(q.pop_front());
         if (p) q.push_back(model(mode, instr, pc));
      end
   end

   always @(negedge clk)
      if (!rst) begin
         chk("count", 32'(count), 32'(q.size()));
         chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
         chk("imm_out", imm_out, q.size() > 0 ? q[0][31:0] : 32'd0);
         chk("mode_err", 32'(mode_err), q.size() > 0 ? 32'(q[0][32]) : 32'd0);
      end

   task automatic req(input logic [2:0] m, input logic [31:0] i, input logic [31:0] p);
      mode = m; instr = i; pc = p; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_imm", imm_out, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      rst = 0;
      @(posedge clk); #1;
      req(3'd1, 32'h2408FFFC, 32'h0);        chk("sign", imm_out, 32'hFFFFFFFC);
      req(3'd0, 32'h2408FFFC, 32'h0);        chk("zero", imm_out, 32'h0000FFFC);
      req(3'd2, 32'h3C011234, 32'h0);        chk("lui", imm_out, 32'h12340000);
      req(3'd6, 32'h00021080, 32'h0);        chk("shamt", imm_out, 32'h00000002);
      req(3'd7, 32'h12345678, 32'h0);        chk("rsv_imm", imm_out, 32'h0);
      chk("rsv_err", 32'(mode_err), 32'd1);
      req(3'd4, 32'h1000FFFF, 32'h00400010); chk("btgt", imm_out, 32'h00400010);
      chk("btgt_err", 32'(mode_err), 32'd0);
      req(3'd5, 32'h08000040, 32'hA0000000); chk("jtgt", imm_out, 32'hA0000100);
      req(3'd3, 32'h10008000, 32'h0);        chk("boff", imm_out, 32'hFFFE0000);
      req(3'd4, 32'h00007FFF, 32'hFFFFFFF8); chk("btgt_wrap", imm_out, 32'h0001FFF8);
      @(posedge clk); #1;
      chk("drained", 32'(out_valid), 32'd0);
      out_ready = 0; mode = 3'd0; in_valid = 1;
      instr = 32'h1111; @(posedge clk); #1;
      instr = 32'h2222; @(posedge clk); #1;
      instr = 32'h3333;
      chk("full_ready", 32'(in_ready), 32'd0);
      chk("full_count", 32'(count), 32'd2);
      @(posedge clk); #1;
      chk("stall_count", 32'(count), 32'd2);
      chk("stall_head", imm_out, 32'h1111);
      out_ready = 1; @(posedge clk); #1; out_ready = 0;
      chk("pulse_head", imm_out, 32'h2222);
      @(posedge clk); #1;
      chk("refill_count", 32'(count), 32'd2);
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      chk("order_c", imm_out, 32'h3333);
      @(posedge clk); #1;
      chk("empty_again", 32'(out_valid), 32'd0);
      out_ready = 0;
      req(3'd1, 32'h0000ABCD, 32'h0);
      chk("pre_flush", 32'(count), 32'd1);
      flush = 1; in_valid = 1; instr = 32'h5555;
      @(posedge clk); #1;
      flush = 0; in_valid = 0;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      req(3'd2, 32'h00000001, 32'h0);
      chk("pre_rst", imm_out, 32'h00010000);
      #2 rst = 1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_imm", imm_out, 32'd0);
      chk("arst_count", 32'(count), 32'd0);
      @(posedge clk); #1;
      rst = 0; out_ready = 1;
      req(3'd6, 32'h000007C0, 32'h0);        chk("post_rst", imm_out, 32'd31);
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
